// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU. Each requester owns a
// one-entry response slot that captures the ALU result on the cycle its request is accepted.
module alu_arbiter #(
  parameter int unsigned TAG_W      = 4,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // requester 0
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_a,
  input  logic [31:0]      i_req0_b,
  input  logic [3:0]       i_req0_sel,
  input  logic [TAG_W-1:0] i_req0_tag,
  // requester 1
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_a,
  input  logic [31:0]      i_req1_b,
  input  logic [3:0]       i_req1_sel,
  input  logic [TAG_W-1:0] i_req1_tag,
  // response 0
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [31:0]      o_rsp0_res,
  output logic [TAG_W-1:0] o_rsp0_tag,
  // response 1
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [31:0]      o_rsp1_res,
  output logic [TAG_W-1:0] o_rsp1_tag,
  // shared ALU
  output logic [31:0]      o_alu_a,
  output logic [31:0]      o_alu_b,
  output logic [3:0]       o_alu_sel,
  input  logic [31:0]      i_alu_res
);

  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [31:0]      r_rsp0_res;
  logic [31:0]      r_rsp1_res;
  logic [TAG_W-1:0] r_rsp0_tag;
  logic [TAG_W-1:0] r_rsp1_tag;
  logic             r_rr_ptr;  // requester preferred on the next tie

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A slot that is draining this cycle can be refilled in the same cycle.
  assign w_elig0 = i_req0_valid && (!r_rsp0_valid || i_rsp0_ready);
  assign w_elig1 = i_req1_valid && (!r_rsp1_valid || i_rsp1_ready);

  // Grant selection; reset suppresses all grants so nothing is accepted while in reset.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!i_rst) begin
      if (w_elig0 && w_elig1) begin
        if (PRIO_FIXED || !r_rr_ptr) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
        w_grant0 = w_elig0;
        w_grant1 = w_elig1;
      end
    end
  end

  // Route the granted operands to the shared ALU; idle drives zeros.
  always_comb begin
    o_alu_a   = 32'h0;
    o_alu_b   = 32'h0;
    o_alu_sel = 4'h0;
    if (w_grant0) begin
      o_alu_a   = i_req0_a;
      o_alu_b   = i_req0_b;
      o_alu_sel = i_req0_sel;
    end else if (w_grant1) begin
      o_alu_a   = i_req1_a;
      o_alu_b   = i_req1_b;
      o_alu_sel = i_req1_sel;
    end
  end

  // Round-robin pointer moves to the loser of each grant and holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_grant1) begin
      r_rr_ptr <= 1'b0;
    end
  end

  // Response slot 0: fill on accept, empty on drain without a refill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_res   <= 32'h0;
      r_rsp0_tag   <= '0;
    end else if (w_grant0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_res   <= i_alu_res;
      r_rsp0_tag   <= i_req0_tag;
    end else if (i_rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  // Response slot 1: fill on accept, empty on drain without a refill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_res   <= 32'h0;
      r_rsp1_tag   <= '0;
    end else if (w_grant1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_res   <= i_alu_res;
      r_rsp1_tag   <= i_req1_tag;
    end else if (i_rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp0_res   = r_rsp0_res;
  assign o_rsp1_res   = r_rsp1_res;
  assign o_rsp0_tag   = r_rsp0_tag;
  assign o_rsp1_tag   = r_rsp1_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance (inst 0) and a fixed-priority instance (inst 1)
// share the same stimulus, each with its own ALU model, checked against a slot/preference model.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [3:0]  req_sel   [2];
  logic [3:0]  req_tag   [2];
  logic        rsp_ready [2];

  logic [1:0]  rdy     [2];     // [inst][req]
  logic [1:0]  rsp_v   [2];
  logic [31:0] rsp_res [2][2];
  logic [3:0]  rsp_tag [2][2];
  logic [31:0] alu_a   [2];
  logic [31:0] alu_b   [2];
  logic [3:0]  alu_sel [2];
  logic [31:0] alu_res [2];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: slot occupancy/content and which requester wins a tie.
  bit          m_full [2][2];
  logic [31:0] m_res  [2][2];
  logic [3:0]  m_tag  [2][2];
  int          m_pref [2];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.TAG_W(4), .PRIO_FIXED(g == 1)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req0_valid (req_valid[0]),
      .o_req0_ready (rdy[g][0]),
      .i_req0_a     (req_a[0]),
      .i_req0_b     (req_b[0]),
      .i_req0_sel   (req_sel[0]),
      .i_req0_tag   (req_tag[0]),
      .i_req1_valid (req_valid[1]),
      .o_req1_ready (rdy[g][1]),
      .i_req1_a     (req_a[1]),
      .i_req1_b     (req_b[1]),
      .i_req1_sel   (req_sel[1]),
      .i_req1_tag   (req_tag[1]),
      .o_rsp0_valid (rsp_v[g][0]),
      .i_rsp0_ready (rsp_ready[0]),
      .o_rsp0_res   (rsp_res[g][0]),
      .o_rsp0_tag   (rsp_tag[g][0]),
      .o_rsp1_valid (rsp_v[g][1]),
      .i_rsp1_ready (rsp_ready[1]),
      .o_rsp1_res   (rsp_res[g][1]),
      .o_rsp1_tag   (rsp_tag[g][1]),
      .o_alu_a      (alu_a[g]),
      .o_alu_b      (alu_b[g]),
      .o_alu_sel    (alu_sel[g]),
      .i_alu_res    (alu_res[g])
    );
    always_comb alu_res[g] = alu_f(alu_a[g], alu_b[g], alu_sel[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which requester the model expects to win this cycle (-1 = none).
  function automatic int exp_grant(input int inst);
    bit e0, e1;
    if (rst) return -1;
    e0 = req_valid[0] && (!m_full[inst][0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_full[inst][1] || rsp_ready[1]);
    if (e0 && e1) return (inst == 1) ? 0 : m_pref[inst];
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_tick();
    int g;
    for (int i = 0; i < 2; i++) begin
      g = exp_grant(i);
      if (rst) begin
        for (int n = 0; n < 2; n++) begin
          m_full[i][n] = 1'b0;
          m_res[i][n]  = 32'h0;
          m_tag[i][n]  = 4'h0;
        end
        m_pref[i] = 0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (g == n) begin
            m_full[i][n] = 1'b1;
            m_res[i][n]  = alu_f(req_a[n], req_b[n], req_sel[n]);
            m_tag[i][n]  = req_tag[n];
          end else if (rsp_ready[n]) begin
            m_full[i][n] = 1'b0;
          end
        end
        if (g >= 0) m_pref[i] = 1 - g;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [3:0] tag);
    req_valid[n] = v;
    req_a[n]     = a;
    req_b[n]     = b;
    req_sel[n]   = sel;
    req_tag[n]   = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, $urandom, $urandom, OP_ADD, 4'h1);
    set_req(1, 1'b1, $urandom, $urandom, OP_XOR, 4'h2);
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    advance();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rdy[i] !== 2'b00) begin
          errors++;
          $display("FAIL reset_ready inst%0d: got %b expected 00", i, rdy[i]);
        end
        checks++;
        if (rsp_v[i] !== 2'b00) begin
          errors++;
          $display("FAIL reset_rsp_valid inst%0d: got %b expected 00", i, rsp_v[i]);
        end
        checks++;
        if ({alu_a[i], alu_b[i], alu_sel[i]} !== 68'h0) begin
          errors++;
          $display("FAIL reset_alu inst%0d: got a=%h b=%h sel=%h expected zeros", i, alu_a[i],
                   alu_b[i], alu_sel[i]);
        end
      end
      advance();
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 2'b01) begin
        errors++;
        $display("FAIL reset_first_tie inst%0d: got %b expected 01", i, rdy[i]);
      end
    end
    advance();
  endtask

  task automatic test_single_add();
    set_req(0, 1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
    req_valid[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 2'b01) begin
        errors++;
        $display("FAIL add_ready inst%0d: got %b expected 01", i, rdy[i]);
      end
    end
    advance();
    req_valid[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]} !== {1'b1, 32'd12, 4'd3}) begin
        errors++;
        $display("FAIL add_rsp inst%0d: got v=%b res=%0d tag=%0d expected v=1 res=12 tag=3", i,
                 rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]);
      end
    end
    advance();
  endtask

  task automatic test_alternate();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd3, OP_SUB, 4'd5);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 4'd9);
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rdy[0] !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant k=%0d: got %b expected %b", k, rdy[0],
                 (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      checks++;
      if (alu_sel[0] !== ((k % 2 == 1) ? OP_SLT : OP_SUB)) begin
        errors++;
        $display("FAIL rr_alu_sel k=%0d: got %h", k, alu_sel[0]);
      end
      checks++;
      if (rdy[1] !== 2'b01) begin
        errors++;
        $display("FAIL fixed_grant k=%0d: got %b expected 01", k, rdy[1]);
      end
      if (k > 0) begin
        checks++;
        if (k % 2 == 1) begin
          if ({rsp_v[0], rsp_res[0][0], rsp_tag[0][0]} !== {2'b01, 32'd7, 4'd5}) begin
            errors++;
            $display("FAIL rr_rsp0 k=%0d: got v=%b res=%0d tag=%0d expected v=01 res=7 tag=5",
                     k, rsp_v[0], rsp_res[0][0], rsp_tag[0][0]);
          end
        end else begin
          if ({rsp_v[0], rsp_res[0][1], rsp_tag[0][1]} !== {2'b10, 32'd1, 4'd9}) begin
            errors++;
            $display("FAIL rr_rsp1 k=%0d: got v=%b res=%0d tag=%0d expected v=10 res=1 tag=9",
                     k, rsp_v[0], rsp_res[0][1], rsp_tag[0][1]);
          end
        end
        checks++;
        if ({rsp_v[1], rsp_res[1][0]} !== {2'b01, 32'd7}) begin
          errors++;
          $display("FAIL fixed_rsp k=%0d: got v=%b res=%0d expected v=01 res=7", k, rsp_v[1],
                   rsp_res[1][0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    set_req(0, 1'b1, 32'd100, 32'd23, OP_ADD, 4'd1);
    set_req(1, 1'b1, $urandom, $urandom, OP_XOR, 4'd2);
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 2'b01) begin
        errors++;
        $display("FAIL stall_first inst%0d: got %b expected 01", i, rdy[i]);
      end
    end
    advance();
    for (int k = 1; k < 5; k++) begin
      req_a[1] = $urandom;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rdy[i] !== 2'b10) begin
          errors++;
          $display("FAIL stall_grant inst%0d k=%0d: got %b expected 10", i, k, rdy[i]);
        end
        checks++;
        if ({rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]} !== {1'b1, 32'd123, 4'd1}) begin
          errors++;
          $display("FAIL stall_hold inst%0d k=%0d: got v=%b res=%0d tag=%0d expected 1/123/1",
                   i, k, rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]);
        end
      end
      advance();
    end
    rsp_ready[0] = 1'b1;
    set_req(0, 1'b1, 32'd200, 32'd1, OP_ADD, 4'd4);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rdy[i], rsp_v[i][0]} !== {2'b01, 1'b1}) begin
        errors++;
        $display("FAIL stall_release inst%0d: got rdy=%b v0=%b expected 01/1", i, rdy[i],
                 rsp_v[i][0]);
      end
    end
    advance();
    req_valid[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]} !== {1'b1, 32'd201, 4'd4}) begin
        errors++;
        $display("FAIL stall_reload inst%0d: got v=%b res=%0d tag=%0d expected 1/201/4", i,
                 rsp_v[i][0], rsp_res[i][0], rsp_tag[i][0]);
      end
    end
    advance();
  endtask

  task automatic test_reset_full();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, OP_SRA, 4'hA);
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 2'b10) begin
      errors++;
      $display("FAIL rfull_grant1: got %b expected 10", rdy[0]);
    end
    advance();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, OP_ADD, 4'd0);
    @(negedge clk);
    checks++;
    if ({rdy[0], rsp_v[0][1], rsp_res[0][1], rsp_tag[0][1]} !== {2'b01, 1'b1, 32'hF800_0000,
                                                                4'hA}) begin
      errors++;
      $display("FAIL rfull_sra: got rdy=%b v1=%b res=%h tag=%h expected 01/1/f8000000/a",
               rdy[0], rsp_v[0][1], rsp_res[0][1], rsp_tag[0][1]);
    end
    advance();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    advance();
    rst = 1'b0;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_v[0], rdy[0]} !== {2'b00, 2'b01}) begin
      errors++;
      $display("FAIL rfull_after_reset: got v=%b rdy=%b expected 00/01", rsp_v[0], rdy[0]);
    end
    advance();
  endtask

  task automatic test_random();
    int g;
    logic [31:0] ea, eb;
    logic [3:0]  es;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int n = 0; n < 2; n++) begin
        req_valid[n] = ($urandom_range(0, 3) != 0);
        req_a[n]     = $urandom;
        req_b[n]     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        req_sel[n]   = 4'($urandom_range(0, 9));
        req_tag[n]   = 4'($urandom);
        rsp_ready[n] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        g  = exp_grant(i);
        ea = (g == 0) ? req_a[0]   : (g == 1) ? req_a[1]   : 32'h0;
        eb = (g == 0) ? req_b[0]   : (g == 1) ? req_b[1]   : 32'h0;
        es = (g == 0) ? req_sel[0] : (g == 1) ? req_sel[1] : 4'h0;
        checks++;
        if (rdy[i] !== {g == 1, g == 0}) begin
          errors++;
          $display("FAIL rand_ready inst%0d cyc%0d: got %b expected %b", i, c, rdy[i],
                   {g == 1, g == 0});
        end
        checks++;
        if ({alu_a[i], alu_b[i], alu_sel[i]} !== {ea, eb, es}) begin
          errors++;
          $display("FAIL rand_alu inst%0d cyc%0d: got %h/%h/%h expected %h/%h/%h", i, c,
                   alu_a[i], alu_b[i], alu_sel[i], ea, eb, es);
        end
        for (int n = 0; n < 2; n++) begin
          checks++;
          if (rsp_v[i][n] !== m_full[i][n]) begin
            errors++;
            $display("FAIL rand_rsp_valid inst%0d req%0d cyc%0d: got %b expected %b", i, n, c,
                     rsp_v[i][n], m_full[i][n]);
          end
          if (m_full[i][n]) begin
            checks++;
            if ({rsp_res[i][n], rsp_tag[i][n]} !== {m_res[i][n], m_tag[i][n]}) begin
              errors++;
              $display("FAIL rand_rsp_data inst%0d req%0d cyc%0d: got %h/%h expected %h/%h",
                       i, n, c, rsp_res[i][n], rsp_tag[i][n], m_res[i][n], m_tag[i][n]);
            end
          end
        end
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pref[i] = 0;
      for (int n = 0; n < 2; n++) begin
        m_full[i][n] = 1'b0;
        m_res[i][n]  = 32'h0;
        m_tag[i][n]  = 4'h0;
      end
    end
    test_reset();
    test_single_add();
    test_alternate();
    test_stall();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
